// File: rtl/timer_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_if
//  Description : Keypad / door / datapath handshake bundle for the microwave
//                timer entry controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_entry_if;
    // Keypad and door inputs, datapath status
    logic       key_pressed;
    logic [3:0] key_code;
    logic       door_closed;
    logic       timer_busy;

    // BCD entry buffer and digit count
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;

    // Single-cycle strobes
    logic       key_ack;
    logic       load_pulse;
    logic       start_pulse;
    logic       stop_pulse;
    logic       entry_error;

    // Environment side: drives keys, door and busy; observes controller
    modport master (
        output key_pressed, key_code, door_closed, timer_busy,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_count,
        input  key_ack, load_pulse, start_pulse, stop_pulse, entry_error
    );

    // Controller side
    modport slave (
        input  key_pressed, key_code, door_closed, timer_busy,
        output min_tens, min_ones, sec_tens, sec_ones, digit_count,
        output key_ack, load_pulse, start_pulse, stop_pulse, entry_error
    );
endinterface
`default_nettype wire

// File: rtl/timer_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : timer_entry_controller
//  Description : Keypad debouncer and MM:SS entry sequencer for the microwave
//                timer; issues load/start/stop strobes to the countdown path.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUICK_START_SEC = 30
) (
    input  wire logic    clock,
    input  wire logic    clear,
    timer_entry_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        STARTING = 2'd2,
        RUNNING  = 2'd3
    } state_t;

    localparam logic [2:0] DEB_TARGET  = 3'(DEBOUNCE_CYCLES);
    localparam logic [2:0] DEB_MAX     = 3'd7;
    localparam logic [3:0] QS_TENS     = 4'(QUICK_START_SEC / 10);
    localparam logic [3:0] QS_ONES     = 4'(QUICK_START_SEC % 10);
    localparam logic [3:0] CODE_DIGMAX = 4'd9;
    localparam logic [3:0] CODE_START  = 4'd10;
    localparam logic [3:0] CODE_CANCEL = 4'd11;

    state_t     state, state_nxt;

    // Debounce registers
    logic [2:0] deb_count, deb_count_nxt;
    logic       lock, lock_nxt;
    logic [3:0] prev_code;
    logic       accept;

    // Entry buffer and strobes
    logic [3:0] min_tens, min_tens_nxt;
    logic [3:0] min_ones, min_ones_nxt;
    logic [3:0] sec_tens, sec_tens_nxt;
    logic [3:0] sec_ones, sec_ones_nxt;
    logic [2:0] digit_count, digit_count_nxt;
    logic       seen_busy, seen_busy_nxt;
    logic       key_ack, load_pulse, start_pulse, stop_pulse, entry_error;
    logic       load_nxt, start_nxt, stop_nxt, error_nxt;

    logic       is_digit, is_start, is_cancel;

    assign is_digit  = accept && (bus.key_code <= CODE_DIGMAX);
    assign is_start  = accept && (bus.key_code == CODE_START);
    assign is_cancel = accept && (bus.key_code == CODE_CANCEL);

    // Debounce: count stable pressed cycles, accept once per press
    always_comb begin
        deb_count_nxt = deb_count;
        lock_nxt      = lock;
        accept        = 1'b0;
        if (!bus.key_pressed) begin
            deb_count_nxt = 3'd0;
            lock_nxt      = 1'b0;
        end else begin
            if (bus.key_code != prev_code) begin
                deb_count_nxt = 3'd1;
            end else if (deb_count != DEB_MAX) begin
                deb_count_nxt = deb_count + 3'd1;
            end
            // Unused codes still lock so a held unused key never repeats
            if ((deb_count_nxt == DEB_TARGET) && !lock) begin
                lock_nxt = 1'b1;
                accept   = (bus.key_code <= CODE_CANCEL);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clock) begin
        if (clear) begin
            deb_count <= 3'd0;
            lock      <= 1'b0;
            prev_code <= 4'd0;
        end else begin
            deb_count <= deb_count_nxt;
            lock      <= lock_nxt;
            prev_code <= bus.key_code;
        end
    end

    // Sequencer next-state, buffer and strobe decisions
    always_comb begin
        state_nxt       = state;
        min_tens_nxt    = min_tens;
        min_ones_nxt    = min_ones;
        sec_tens_nxt    = sec_tens;
        sec_ones_nxt    = sec_ones;
        digit_count_nxt = digit_count;
        seen_busy_nxt   = seen_busy;
        load_nxt        = 1'b0;
        start_nxt       = 1'b0;
        stop_nxt        = 1'b0;
        error_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (is_digit) begin
                    min_tens_nxt    = 4'd0;
                    min_ones_nxt    = 4'd0;
                    sec_tens_nxt    = 4'd0;
                    sec_ones_nxt    = bus.key_code;
                    digit_count_nxt = 3'd1;
                    state_nxt       = ENTRY;
                end else if (is_start) begin
                    if (bus.door_closed) begin
                        // Quick start: load a fixed seconds value
                        min_tens_nxt = 4'd0;
                        min_ones_nxt = 4'd0;
                        sec_tens_nxt = QS_TENS;
                        sec_ones_nxt = QS_ONES;
                        load_nxt     = 1'b1;
                        state_nxt    = STARTING;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end

            ENTRY: begin
                if (is_digit) begin
                    if (digit_count < 3'd4) begin
                        min_tens_nxt    = min_ones;
                        min_ones_nxt    = sec_tens;
                        sec_tens_nxt    = sec_ones;
                        sec_ones_nxt    = bus.key_code;
                        digit_count_nxt = digit_count + 3'd1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end else if (is_cancel) begin
                    min_tens_nxt    = 4'd0;
                    min_ones_nxt    = 4'd0;
                    sec_tens_nxt    = 4'd0;
                    sec_ones_nxt    = 4'd0;
                    digit_count_nxt = 3'd0;
                    state_nxt       = IDLE;
                end else if (is_start) begin
                    if (!bus.door_closed || (sec_tens > 4'd5)) begin
                        error_nxt = 1'b1;
                    end else begin
                        load_nxt  = 1'b1;
                        state_nxt = STARTING;
                    end
                end
            end

            // One cycle after load so load and start never coincide
            STARTING: begin
                start_nxt     = 1'b1;
                seen_busy_nxt = 1'b0;
                state_nxt     = RUNNING;
            end

            RUNNING: begin
                if (bus.timer_busy) begin
                    seen_busy_nxt = 1'b1;
                end
                if (is_cancel || !bus.door_closed || (seen_busy && !bus.timer_busy)) begin
                    // A natural finish alone needs no stop strobe
                    stop_nxt        = is_cancel || !bus.door_closed;
                    min_tens_nxt    = 4'd0;
                    min_ones_nxt    = 4'd0;
                    sec_tens_nxt    = 4'd0;
                    sec_ones_nxt    = 4'd0;
                    digit_count_nxt = 3'd0;
                    seen_busy_nxt   = 1'b0;
                    state_nxt       = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer, flag and strobe registers
    always_ff @(posedge clock) begin
        if (clear) begin
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            digit_count <= 3'd0;
            seen_busy   <= 1'b0;
            key_ack     <= 1'b0;
            load_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            min_tens    <= min_tens_nxt;
            min_ones    <= min_ones_nxt;
            sec_tens    <= sec_tens_nxt;
            sec_ones    <= sec_ones_nxt;
            digit_count <= digit_count_nxt;
            seen_busy   <= seen_busy_nxt;
            key_ack     <= accept;
            load_pulse  <= load_nxt;
            start_pulse <= start_nxt;
            stop_pulse  <= stop_nxt;
            entry_error <= error_nxt;
        end
    end

    assign bus.min_tens    = min_tens;
    assign bus.min_ones    = min_ones;
    assign bus.sec_tens    = sec_tens;
    assign bus.sec_ones    = sec_ones;
    assign bus.digit_count = digit_count;
    assign bus.key_ack     = key_ack;
    assign bus.load_pulse  = load_pulse;
    assign bus.start_pulse = start_pulse;
    assign bus.stop_pulse  = stop_pulse;
    assign bus.entry_error = entry_error;

endmodule
`default_nettype wire

// File: tb/tb_timer_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_entry_controller
//  Description : Directed self-checking bench for timer_entry_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_entry_controller;

    logic clock;
    logic clear;

    timer_entry_if bus ();

    timer_entry_controller #(
        .DEBOUNCE_CYCLES(4),
        .QUICK_START_SEC(30)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pulse tallies gathered once per cycle
    int n_ack = 0, n_err = 0, n_load = 0, n_start = 0, n_stop = 0;
    int s_ack, s_err, s_load, s_start, s_stop;
    int overlap = 0, bad_seq = 0;
    logic prev_load = 1'b0;
    int first_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        n_ack   += int'(bus.key_ack);
        n_err   += int'(bus.entry_error);
        n_load  += int'(bus.load_pulse);
        n_start += int'(bus.start_pulse);
        n_stop  += int'(bus.stop_pulse);
        if (bus.load_pulse && bus.start_pulse) overlap++;
        if (bus.start_pulse && !prev_load) bad_seq++;
        prev_load = bus.load_pulse;
    endtask

    task automatic snap();
        s_ack = n_ack; s_err = n_err; s_load = n_load; s_start = n_start; s_stop = n_stop;
    endtask

    // Hold a key for 'hold' cycles, release, then let two cycles pass
    task automatic press(input logic [3:0] code, input int hold);
        first_ack = 0;
        bus.key_code    = code;
        bus.key_pressed = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (bus.key_ack && first_ack == 0) first_ack = i;
        end
        bus.key_pressed = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [15:0] buffer();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clear           = 1'b1;
        bus.key_pressed = 1'b0;
        bus.key_code    = 4'd0;
        bus.door_closed = 1'b1;
        bus.timer_busy  = 1'b0;
        tick(); tick(); tick();
        check("reset_buffer", 32'(buffer()), 32'h0000);
        check("reset_count", 32'(bus.digit_count), 0);
        check("reset_pulses", 32'({bus.key_ack, bus.load_pulse, bus.start_pulse,
                                   bus.stop_pulse, bus.entry_error}), 0);
        clear = 1'b0;
        tick();

        // Short press is filtered out
        snap();
        press(4'd7, 3);
        check("short_no_ack", 32'(n_ack - s_ack), 0);
        check("short_count", 32'(bus.digit_count), 0);

        // Long press yields exactly one ack on the 4th edge
        snap();
        press(4'd7, 10);
        check("long_ack_count", 32'(n_ack - s_ack), 1);
        check("long_ack_edge", 32'(first_ack), 4);
        check("long_sec_ones", 32'(bus.sec_ones), 7);
        check("long_count", 32'(bus.digit_count), 1);

        // Cancel from entry
        press(4'd11, 5);
        check("cancel1_buffer", 32'(buffer()), 32'h0000);
        check("cancel1_count", 32'(bus.digit_count), 0);

        // Four digits then a rejected fifth
        press(4'd1, 5);
        press(4'd2, 5);
        press(4'd3, 5);
        press(4'd0, 5);
        snap();
        press(4'd9, 5);
        check("full_buffer", 32'(buffer()), 32'h1230);
        check("full_count", 32'(bus.digit_count), 4);
        check("full_error", 32'(n_err - s_err), 1);
        check("full_ack", 32'(n_ack - s_ack), 1);

        // Start with door closed
        snap();
        press(4'd10, 5);
        check("start_load", 32'(n_load - s_load), 1);
        check("start_start", 32'(n_start - s_start), 1);
        check("start_no_err", 32'(n_err - s_err), 0);
        check("run_buffer_held", 32'(buffer()), 32'h1230);

        // Natural finish: busy then idle, no stop strobe
        snap();
        bus.timer_busy = 1'b1;
        tick(); tick(); tick();
        bus.timer_busy = 1'b0;
        tick(); tick();
        check("natural_no_stop", 32'(n_stop - s_stop), 0);
        check("natural_buffer", 32'(buffer()), 32'h0000);
        check("natural_count", 32'(bus.digit_count), 0);

        // Invalid seconds tens: 0,7,5 -> sec_tens 7
        press(4'd0, 5);
        press(4'd7, 5);
        press(4'd5, 5);
        check("bad_buffer", 32'(buffer()), 32'h0075);
        snap();
        press(4'd10, 5);
        check("bad_error", 32'(n_err - s_err), 1);
        check("bad_no_load", 32'(n_load - s_load), 0);
        check("bad_stays_entry", 32'(bus.digit_count), 3);
        press(4'd11, 5);
        check("cancel2_buffer", 32'(buffer()), 32'h0000);
        check("cancel2_count", 32'(bus.digit_count), 0);

        // Quick start with door open is rejected
        bus.door_closed = 1'b0;
        snap();
        press(4'd10, 5);
        check("qs_open_error", 32'(n_err - s_err), 1);
        check("qs_open_no_load", 32'(n_load - s_load), 0);

        // Quick start with door closed loads 00:30
        bus.door_closed = 1'b1;
        snap();
        press(4'd10, 5);
        check("qs_load", 32'(n_load - s_load), 1);
        check("qs_start", 32'(n_start - s_start), 1);
        check("qs_buffer", 32'(buffer()), 32'h0030);

        // Door opened mid-run gives a single stop
        snap();
        bus.timer_busy = 1'b1;
        tick(); tick();
        bus.door_closed = 1'b0;
        tick(); tick(); tick();
        check("door_stop", 32'(n_stop - s_stop), 1);
        check("door_buffer", 32'(buffer()), 32'h0000);
        bus.door_closed = 1'b1;
        bus.timer_busy  = 1'b0;
        tick(); tick();

        // Clear during a run while key 4 is held
        press(4'd10, 5);
        check("pre_clear_buffer", 32'(buffer()), 32'h0030);
        bus.key_code    = 4'd4;
        bus.key_pressed = 1'b1;
        clear           = 1'b1;
        tick();
        check("clear_buffer", 32'(buffer()), 32'h0000);
        check("clear_count", 32'(bus.digit_count), 0);
        check("clear_pulses", 32'({bus.key_ack, bus.load_pulse, bus.start_pulse,
                                   bus.stop_pulse, bus.entry_error}), 0);
        clear     = 1'b0;
        first_ack = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.key_ack && first_ack == 0) first_ack = i;
        end
        bus.key_pressed = 1'b0;
        tick(); tick();
        check("post_clear_ack_edge", 32'(first_ack), 4);
        check("post_clear_sec_ones", 32'(bus.sec_ones), 4);
        check("post_clear_count", 32'(bus.digit_count), 1);

        check("load_start_overlap", 32'(overlap), 0);
        check("start_after_load", 32'(bad_seq), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_entry_controller.md
Name: timer_entry_controller

Overview:
Keypad front end and sequencer for the microwave timer. Debounces raw key presses, turns each press into a single-cycle accept, and shifts BCD digits into an MM:SS entry buffer. Handles start, cancel and door interlock, and issues load, start and stop strobes to the countdown datapath downstream.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable sampled cycles needed to accept a key (legal range 1..7; 3-bit saturating counter).
QUICK_START_SEC, 30, seconds loaded when start is pressed with an empty buffer (legal range 0..59).

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
key_pressed  in  1  raw key-down level
key_code  in  4  0-9 = digit, 10 = start, 11 = cancel, 12-15 = unused
door_closed  in  1  1 = door latched
timer_busy  in  1  countdown datapath running
min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD entry buffer
digit_count  out  3  digits entered, 0..4
key_ack  out  1  one-cycle pulse per accepted code 0-11
load_pulse  out  1  one cycle; datapath captures the 4 BCD outputs
start_pulse  out  1  one cycle; datapath begins countdown
stop_pulse  out  1  one cycle; datapath halts
entry_error  out  1  one-cycle pulse on a rejected action

Behaviour:
- clear (sync, active-high) on any edge: all outputs 0, state IDLE, debounce count 0, release lock 0. A key held through clear is re-debounced from 0.
- Debounce:
  - count increments on each edge with key_pressed=1 and key_code equal to the previous cycle's code. Code change while pressed resets count to 1.
  - key_pressed=0 resets count to 0 and release lock to 0.
  - Accept fires on the edge where count reaches DEBOUNCE_CYCLES and lock=0. That edge sets lock=1, so there is no repeat until release.
  - Key rising before edge k gives accept at edge k+DEBOUNCE_CYCLES-1.
- Codes 12-15 are never accepted: no ack, no effect.
- On accept, all registered effects land on the same edge: key_ack=1, plus the state actions below. Every pulse output is high for exactly one cycle.
- State IDLE (digit_count=0):
  - Digit: sec_ones<=d, digit_count=1, go to ENTRY.
  - Start with door_closed=1: load buffer 0:QUICK_START_SEC (30 gives min 0,0 sec 3,0) and load_pulse=1. Next edge start_pulse=1 and state RUNNING.
  - Start with door open: entry_error.
  - Cancel: no-op, ack only.
- State ENTRY:
  - Digit with digit_count<4: shift left (min_tens<=min_ones<=sec_tens<=sec_ones<=d), count+1.
  - Digit with digit_count=4: entry_error, buffer unchanged.
  - Cancel: buffer and count cleared, go to IDLE.
  - Start: entry_error and stay in ENTRY if door_closed=0 or sec_tens>5. Otherwise load_pulse now, start_pulse next edge, then RUNNING. The buffer is held.
- State RUNNING:
  - Digits and start are ignored, ack only.
  - seen_busy flag sets when timer_busy=1.
  - Cancel, or door_closed=0, or (seen_busy and timer_busy=0): stop_pulse=1 (suppressed for a natural finish), buffer and count cleared, go to IDLE.
  - Cancel and door opening on the same edge give a single stop_pulse.
- load_pulse and start_pulse are never high in the same cycle. Door opening in the start_pulse cycle is handled on the following edge (stop_pulse).

Test Plan:
- DEBOUNCE_CYCLES=4. key_code=7 held 3 cycles then released -> no key_ack. Held 10 cycles -> exactly one key_ack at the 4th edge, sec_ones=7, digit_count=1.
- Enter 1,2,3,0 then a 5th digit 9 -> buffer 12:30, digit_count=4, one entry_error on the 9. Start with door closed -> load_pulse, then start_pulse next cycle.
- Enter 0,7,5 (7:5 gives sec_tens=7) then start -> entry_error, no load_pulse, state ENTRY. Cancel -> all digits 0, digit_count=0.
- Empty buffer, door open, start -> entry_error. Close door, start -> buffer 00:30, load_pulse, start_pulse.
- RUNNING with timer_busy 1 then 0 -> IDLE with no stop_pulse. Second run with door opened mid-run -> one stop_pulse, buffer cleared.
- Assert clear during RUNNING while key 4 is held -> all outputs 0 next cycle. Key 4 accepted DEBOUNCE_CYCLES edges after clear deasserts.
